// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR sequencer: command ops, FSM state codes and
// default polynomial/seed.
package lfsr_pkg;

  localparam logic [1:0] OP_STOP     = 2'd0;
  localparam logic [1:0] OP_LOAD     = 2'd1;
  localparam logic [1:0] OP_RUN_N    = 2'd2;
  localparam logic [1:0] OP_FREE_RUN = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FREE  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // x^8 + x^6 + x^5 + x^4 + 1 style mask, maximal length for 8 bits
  localparam logic [7:0] LFSR_TAPS_DEF = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEF = 8'hAA;

endpackage

// File: rtl/lfsr_step.sv
// Combinational Fibonacci LFSR next-state: XOR of tapped bits shifted in at LSB.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_DEF)
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);

  logic fb;

  // feedback parity and shift
  always_comb begin
    fb   = ^(state & TAPS);
    next = {state[WIDTH-2:0], fb};
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Command-driven LFSR sequencer: LOAD / RUN_N / FREE_RUN / STOP, stepping on a
// tick strobe and presenting each value on a valid/ready port.
// Optional period checker: define LFSR_SEQ_CTRL_PERIOD_CHK_EN.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(LFSR_TAPS_DEF),
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(LFSR_SEED_DEF),
  parameter int               CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_seed,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  logic [1:0]       state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] nxt;
  logic [CNT_W-1:0] remaining;
  logic             stepping;
  logic             step;
  logic             hs;
  logic             cmd_acc;
  logic             load_acc;
  logic [WIDTH-1:0] seed_eff;

  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
    .state (lfsr),
    .next  (nxt)
  );

  assign cmd_ready = (state == ST_IDLE) || (state == ST_FREE);
  assign busy      = (state != ST_IDLE);

  // step qualification: a tick only advances when the output slot is free or being drained
  always_comb begin
    stepping = (state == ST_RUN) || (state == ST_FREE);
    step     = stepping && tick && (!out_valid || out_ready);
    hs       = out_valid && out_ready;
    cmd_acc  = cmd_valid && cmd_ready;
    load_acc = cmd_acc && (state == ST_IDLE) && (cmd_op == OP_LOAD);
    seed_eff = (cmd_seed == '0) ? SEED_DEFAULT : cmd_seed;
  end

  // FSM, LFSR state and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lfsr      <= SEED_DEFAULT;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (step) begin
        lfsr      <= nxt;
        out_data  <= nxt;
        out_valid <= 1'b1;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
      // a held value is never overwritten, so the tick is lost instead
      if (stepping && tick && out_valid && !out_ready) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (cmd_acc) begin
            case (cmd_op)
              OP_LOAD: begin
                lfsr    <= seed_eff;
                overrun <= 1'b0;
              end
              OP_RUN_N: begin
                if (cmd_count == '0) begin
                  done <= 1'b1;
                end else begin
                  remaining <= cmd_count;
                  state     <= ST_RUN;
                end
              end
              OP_FREE_RUN: state <= ST_FREE;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (step) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state <= ST_DRAIN;
          end
        end
        ST_FREE: begin
          if (cmd_acc) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!out_valid || out_ready) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LFSR_SEQ_CTRL_PERIOD_CHK_EN
  logic [WIDTH-1:0] period_cnt;
  logic [WIDTH-1:0] seed_reg;

  // count steps since LOAD; capture the first return to the loaded seed
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt   <= '0;
      seed_reg     <= SEED_DEFAULT;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (load_acc) begin
      period_cnt   <= '0;
      seed_reg     <= seed_eff;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (step) begin
      period_cnt <= period_cnt + WIDTH'(1);
      if (!period_valid && (nxt == seed_reg)) begin
        period       <= period_cnt + WIDTH'(1);
        period_valid <= 1'b1;
      end
    end
  end
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl: directed scenarios plus randomized
// RUN_N traffic checked against a parity-based sequence model.
// Period checks follow LFSR_SEQ_CTRL_PERIOD_CHK_EN.
module tb_lfsr_seq_ctrl;

  localparam int         WIDTH = 8;
  localparam int         CNT_W = 16;
  localparam logic [7:0] M_TAPS = 8'hB8;
  localparam logic [7:0] M_SEED = 8'hAA;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_seed;
  logic [CNT_W-1:0] cmd_count;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             done;
  logic             overrun;
  logic [WIDTH-1:0] period;
  logic             period_valid;

  int errs   = 0;
  int checks = 0;

  logic [7:0] got[$];
  logic [7:0] m_lfsr;

  always #5 clk = ~clk;

  lfsr_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_seed     (cmd_seed),
    .cmd_count    (cmd_count),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .period       (period),
    .period_valid (period_valid)
  );

  // record every value the consumer accepts
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back(out_data);
  end

  // model: shift left, new LSB is parity of tapped bits
  function automatic logic [7:0] m_step(input logic [7:0] s);
    logic fb;
    fb = ($countones(s & M_TAPS) % 2) == 1;
    return {s[6:0], fb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] seed, input logic [15:0] cnt);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_seed  = seed;
    cmd_count = cnt;
    while (!cmd_ready && n < 50) begin
      cyc();
      n++;
    end
    chk("cmd_ready", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      cyc();
      n++;
    end
    chk(tag, done, 1);
  endtask

  // compare the accepted values against the model sequence from m_lfsr
  task automatic chk_seq(input string tag, input int exp_len);
    chk({tag, "_len"}, got.size(), exp_len);
    for (int i = 0; i < got.size(); i++) begin
      m_lfsr = m_step(m_lfsr);
      chk({tag, "_val"}, got[i], m_lfsr);
    end
  endtask

  initial begin
    int n;
    int cnt;
    int mper;
    logic [7:0] s;

    rst = 1'b1; tick = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0;
    cmd_seed = '0; cmd_count = '0; out_ready = 1'b0;
    cyc(); cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_period", period, 0);
    chk("rst_period_valid", period_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    cyc();

    // basic run, one value per cycle
    got.delete();
    send_cmd(2'd1, 8'hAA, 0);
    tick = 1'b1; out_ready = 1'b1;
    send_cmd(2'd2, 8'h00, 3);
    chk("basic_busy", busy, 1);
    cyc(); chk("basic_v0", out_valid, 1); chk("basic_d0", out_data, 8'h55);
    cyc(); chk("basic_v1", out_valid, 1); chk("basic_d1", out_data, 8'hAB);
    cyc(); chk("basic_v2", out_valid, 1); chk("basic_d2", out_data, 8'h57);
    cyc(); chk("basic_done", done, 1); chk("basic_idle", busy, 0);
    m_lfsr = 8'hAA;
    chk_seq("basic", 3);
    cyc(); chk("basic_done_pulse", done, 0);

    // backpressure with dropped ticks
    got.delete();
    tick = 1'b0;
    send_cmd(2'd1, 8'hAA, 0);
    tick = 1'b1; out_ready = 1'b1;
    send_cmd(2'd2, 8'h00, 3);
    cyc(); chk("bp_first", out_data, 8'h55);
    out_ready = 1'b0;
    repeat (5) cyc();
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_data", out_data, 8'h55);
    chk("bp_overrun", overrun, 1);
    out_ready = 1'b1;
    wait_done("bp_done", 50);
    m_lfsr = 8'hAA;
    chk_seq("bp", 3);

    // zero seed falls back to the default, LOAD clears overrun
    got.delete();
    tick = 1'b0;
    send_cmd(2'd1, 8'h00, 0);
    chk("zs_overrun_clr", overrun, 0);
    tick = 1'b1;
    send_cmd(2'd2, 8'h00, 1);
    wait_done("zs_done", 50);
    m_lfsr = M_SEED;
    chk_seq("zs", 1);

    // free run then STOP
    got.delete();
    send_cmd(2'd3, 8'h00, 0);
    n = 0;
    while (got.size() < 10 && n < 100) begin cyc(); n++; end
    chk("fr_steps", got.size() >= 10, 1);
    chk("fr_ready_in_free", cmd_ready, 1);
    send_cmd(2'd0, 8'h00, 0);
    wait_done("fr_done", 50);
    cnt = got.size();
    chk_seq("fr", cnt);
    repeat (5) cyc();
    chk("fr_no_more", got.size(), cnt);
    chk("fr_out_valid", out_valid, 0);
    send_cmd(2'd2, 8'h00, 0);
    chk("run0_done", done, 1);
    chk("run0_busy", busy, 0);
    cyc();
    chk("run0_no_out", got.size(), cnt);

    // randomized RUN_N traffic with random tick and backpressure
    for (int it = 0; it < 20; it++) begin
      got.delete();
      tick = 1'b0; out_ready = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        s = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) s = 8'h00;
        send_cmd(2'd1, s, 0);
        m_lfsr = (s == 8'h00) ? M_SEED : s;
      end
      cnt = $urandom_range(0, 12);
      send_cmd(2'd2, 8'h00, 16'(cnt));
      if (cnt == 0) begin
        chk("rnd_run0_done", done, 1);
      end else begin
        n = 0;
        while (!done && n < 500) begin
          tick      = $urandom_range(0, 1) == 1;
          out_ready = $urandom_range(0, 2) != 0;
          cyc();
          n++;
        end
        chk("rnd_done", done, 1);
      end
      chk_seq("rnd", cnt);
    end
    tick = 1'b0; out_ready = 1'b1;
    cyc();

    // period of a maximal-length 8-bit sequence from seed 1
    mper = 0;
    s = 8'h01;
    do begin s = m_step(s); mper++; end while (s != 8'h01 && mper < 1000);
    got.delete();
    send_cmd(2'd1, 8'h01, 0);
    tick = 1'b1; out_ready = 1'b1;
    send_cmd(2'd3, 8'h00, 0);
`ifdef LFSR_SEQ_CTRL_PERIOD_CHK_EN
    n = 0;
    while (!period_valid && n < 400) begin cyc(); n++; end
    chk("per_valid", period_valid, 1);
    chk("per_value", period, mper & 8'hFF);
`else
    repeat (300) cyc();
    chk("per_off_value", period, 0);
    chk("per_off_valid", period_valid, 0);
`endif
    send_cmd(2'd0, 8'h00, 0);
    wait_done("per_done", 50);
    m_lfsr = 8'h01;
    chk_seq("per", got.size());

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
- Command-driven sequencer for a Fibonacci LFSR (default 8-bit, taps 7,5,4,3; maximal length).
- Owns the LFSR state and handles seed loading, N-step runs, free-run and stop.
- Advances on a single-cycle `tick` strobe from the clock-divider counter, not on a derived clock.
- Each new value is delivered over a valid/ready output port, with backpressure and overrun reporting.

Parameters:
- WIDTH, 8: LFSR width.
- TAPS, 8'hB8: feedback tap mask. Bit i set means state[i] is XORed into the feedback.
- SEED_DEFAULT, 8'hAA: reset state, and the substitute used when a zero seed is loaded.
- CNT_W, 16: width of the RUN_N step count.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- tick  in  1  step strobe, one clk wide
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_op  in  2  0=STOP, 1=LOAD, 2=RUN_N, 3=FREE_RUN
- cmd_seed  in  WIDTH  seed for LOAD
- cmd_count  in  CNT_W  step count for RUN_N
- out_valid  out  1  out_data holds an unconsumed LFSR value
- out_ready  in  1  consumer accepts out_data
- out_data  out  WIDTH  LFSR value after the most recent step
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when RUN_N or STOP completes
- overrun  out  1  sticky: a tick was dropped
- period  out  WIDTH  see Optional Feature
- period_valid  out  1  see Optional Feature

Behaviour:
- Clock and reset: one clock, `clk`. `rst` is synchronous and active-high and wins over every other input.
- Reset values: state=IDLE, lfsr=SEED_DEFAULT, out_valid=0, out_data=0, done=0, overrun=0, period=0, period_valid=0.
- Reset mid-operation: aborts immediately; any pending output is discarded.
- Step function (lfsr_step):
  - fb = XOR of state[i] over all i where TAPS[i]=1.
  - next = {state[WIDTH-2:0], fb}.
- States: IDLE, RUN, FREE, DRAIN.
- cmd_ready=1 in IDLE and FREE; 0 in RUN and DRAIN.
- IDLE:
  - LOAD: lfsr <= (cmd_seed==0 ? SEED_DEFAULT : cmd_seed); clears overrun; stays IDLE. No output is produced.
  - RUN_N with count 0: done pulses on the next cycle; stays IDLE.
  - RUN_N with count>0: remaining <= count; go to RUN.
  - FREE_RUN: go to FREE.
  - STOP: no effect.
- Step condition, in RUN or FREE:
  - step = tick && (!out_valid || out_ready).
  - On step: lfsr <= next; out_data <= next; out_valid <= 1 on the following cycle. Latency is one clk from tick to out_valid.
  - out_valid clears on handshake when no simultaneous step occurs.
  - A simultaneous handshake and step keeps out_valid=1 with the new data.
- Dropped tick: tick && out_valid && !out_ready drops the tick and sets overrun. The LFSR never skips a value.
- RUN: each step decrements remaining. The step taking remaining to 0 moves the FSM to DRAIN.
- FREE: any accepted command, whatever its op, acts as STOP and moves the FSM to DRAIN. A tick in the same cycle is still honoured.
- DRAIN:
  - No steps occur.
  - When out_valid==0, or on the cycle out_valid&&out_ready: done=1 for one cycle, then IDLE.
- The LFSR state persists across runs. A later RUN continues the sequence unless it is reloaded.

Optional Feature:
- Macro: LFSR_SEQ_CTRL_PERIOD_CHK_EN.
- Enabled:
  - A WIDTH-bit counter clears on LOAD and increments on each step.
  - When a step makes next equal the loaded seed, period <= counter+1 and period_valid <= 1 (sticky until the next LOAD or rst).
- Disabled: period and period_valid are tied to 0 and no counter is synthesised.

Decomposition:
- Package lfsr_pkg holds:
  - cmd op encodings: OP_STOP, OP_LOAD, OP_RUN_N, OP_FREE_RUN.
  - state encoding.
  - default TAPS and SEED_DEFAULT constants.
- Sub-module lfsr_step: purely combinational next-state function (WIDTH, TAPS). It is reused by any future LFSR users.

Test Plan:
- Reset check: assert rst for 2 cycles → all outputs at their reset values, cmd_ready=1, busy=0.
- Basic run: LOAD 0xAA, RUN_N 3, tick every cycle, out_ready=1 → out_data 0x55, 0xAB, 0x57 on consecutive cycles; then done pulse; busy=0.
- Backpressure: RUN_N 3 from 0xAA with out_ready=0 for 5 cycles after the first output → out_data holds 0x55 and overrun=1; after release, 0xAB then 0x57 with no skipped values.
- Zero-seed guard: LOAD 0x00, then RUN_N 1 → out_data=0x55, i.e. SEED_DEFAULT was used.
- Free-run stop: FREE_RUN, then STOP after 10 steps → cmd accepted in FREE, DRAIN waits for the final handshake, done pulses, no further steps; a subsequent RUN_N 0 gives done with no output.
- Period check (macro on): LOAD 0x01, FREE_RUN with tick every cycle → period_valid after 255 steps, period=255. Macro off → period stays 0.
